// File: rtl/apb_timer_pkg.sv
// Shared register map for the APB timer: byte offsets, CTRL field positions
// and the STATUS flag position, used by the slave and its testbench.
package apb_timer_pkg;

    localparam logic [3:0] OFFSET_CTRL   = 4'h0;
    localparam logic [3:0] OFFSET_LOAD   = 4'h4;
    localparam logic [3:0] OFFSET_VALUE  = 4'h8;
    localparam logic [3:0] OFFSET_STATUS = 4'hC;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_RELOAD_BIT = 1;
    localparam int CTRL_IE_BIT     = 2;
    localparam int CTRL_PRESC_LSB  = 8;

    localparam int STATUS_FLAG_BIT = 0;

    typedef enum logic [1:0] {
        REG_CTRL   = OFFSET_CTRL[3:2],
        REG_LOAD   = OFFSET_LOAD[3:2],
        REG_VALUE  = OFFSET_VALUE[3:2],
        REG_STATUS = OFFSET_STATUS[3:2]
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [1:0] word_addr);
        return reg_sel_e'(word_addr);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: counts 0..presc while enabled and pulses tick for
// one cycle on the wrap. A clear restarts the count and suppresses that tick.
module timer_prescaler
    import apb_timer_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] count_q;
    logic [PRESC_W-1:0] count_d;

    assign tick = en & ~clr & (count_q == presc);

    always_comb begin
        count_d = count_q;
        if (clr || tick) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB down-counting timer with prescaler, optional auto-reload
// and a write-1-to-clear expiry flag driving a level interrupt.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        IRQ
);

    logic               en_q, en_d;
    logic               reload_q, reload_d;
    logic               ie_q, ie_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        load_q, load_d;
    logic [31:0]        value_q, value_d;
    logic               flag_q, flag_d;

    reg_sel_e           addr_sel;
    logic               wr_strobe;
    logic               ctrl_wr;
    logic               load_wr;
    logic               status_wr;
    logic               presc_clr;
    logic               tick;
    logic               expiry;
    logic [31:0]        ctrl_rdata;
    logic               unused_addr_bits;

    assign addr_sel         = decode_reg(PADDR[3:2]);
    assign unused_addr_bits = ^{PADDR[31:4], PADDR[1:0]};

    assign wr_strobe = PSEL & PENABLE & PWRITE;
    assign ctrl_wr   = wr_strobe & (addr_sel == REG_CTRL);
    assign load_wr   = wr_strobe & (addr_sel == REG_LOAD);
    assign status_wr = wr_strobe & (addr_sel == REG_STATUS);

    // A fresh LOAD or stopping the timer restarts the prescale period from zero.
    assign presc_clr = load_wr | (ctrl_wr & ~PWDATA[CTRL_EN_BIT]);
    assign expiry    = tick & (value_q == 32'd0);

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (HCLK),
        .rst   (HRESET),
        .en    (en_q),
        .clr   (presc_clr),
        .presc (presc_q),
        .tick  (tick)
    );

    always_comb begin
        en_d     = en_q;
        reload_d = reload_q;
        ie_d     = ie_q;
        presc_d  = presc_q;
        load_d   = load_q;
        value_d  = value_q;
        flag_d   = flag_q;

        if (tick) begin
            if (value_q != 32'd0) begin
                value_d = value_q - 32'd1;
            end else if (reload_q) begin
                value_d = load_q;
            end else begin
                en_d = 1'b0;
            end
        end

        if (ctrl_wr) begin
            en_d     = PWDATA[CTRL_EN_BIT];
            reload_d = PWDATA[CTRL_RELOAD_BIT];
            ie_d     = PWDATA[CTRL_IE_BIT];
            presc_d  = PWDATA[CTRL_PRESC_LSB +: PRESC_W];
        end

        if (load_wr) begin
            load_d  = PWDATA;
            value_d = PWDATA;
        end

        // Hardware expiry beats a simultaneous software clear.
        if (expiry) begin
            flag_d = 1'b1;
        end else if (status_wr && PWDATA[STATUS_FLAG_BIT]) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            en_q     <= 1'b0;
            reload_q <= 1'b0;
            ie_q     <= 1'b0;
            presc_q  <= '0;
            load_q   <= 32'd0;
            value_q  <= 32'd0;
            flag_q   <= 1'b0;
        end else begin
            en_q     <= en_d;
            reload_q <= reload_d;
            ie_q     <= ie_d;
            presc_q  <= presc_d;
            load_q   <= load_d;
            value_q  <= value_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        ctrl_rdata                                  = 32'd0;
        ctrl_rdata[CTRL_EN_BIT]                     = en_q;
        ctrl_rdata[CTRL_RELOAD_BIT]                 = reload_q;
        ctrl_rdata[CTRL_IE_BIT]                     = ie_q;
        ctrl_rdata[CTRL_PRESC_LSB +: PRESC_W]       = presc_q;
    end

    always_comb begin
        PRDATA = 32'd0;
        if (PSEL && !PWRITE) begin
            case (addr_sel)
                REG_CTRL:   PRDATA = ctrl_rdata;
                REG_LOAD:   PRDATA = load_q;
                REG_VALUE:  PRDATA = value_q;
                REG_STATUS: PRDATA[STATUS_FLAG_BIT] = flag_q;
            endcase
        end
    end

    assign IRQ = flag_q & ie_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: constant vector table, timed corner
// sequences and random APB traffic against a behavioural register model.
module tb_apb_timer_slave;

    localparam int PRESC_W = 8;

    logic        HCLK;
    logic        HRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        IRQ;

    int checks;
    int errors;

    typedef struct packed {
        logic        en;
        logic        reload;
        logic        ie;
        logic [7:0]  presc;
        logic [31:0] load;
        logic [31:0] value;
        logic        flag;
        logic [7:0]  cnt;
    } model_t;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    model_t m;
    vec_t   vecs[14];

    logic [31:0] rd, mrd, addr, data;
    logic        ri, mri;

    apb_timer_slave #(
        .PRESC_W (PRESC_W)
    ) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .IRQ     (IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Reference model: one clock of the timer expressed as the register rules,
    // hardware effects first and software writes/expiry-set layered on top.
    function automatic model_t model_next(input model_t s, input logic psel,
                                          input logic penable, input logic pwrite,
                                          input logic [31:0] paddr, input logic [31:0] pwdata);
        model_t n;
        bit wr, clr, tick, expire;
        int sel;
        n      = s;
        wr     = psel && penable && pwrite;
        sel    = int'(paddr[3:2]);
        clr    = wr && (sel == 1 || (sel == 0 && !pwdata[0]));
        tick   = s.en && !clr && (s.cnt == s.presc);
        expire = tick && (s.value == 0);
        if (tick && s.value != 0) n.value = s.value - 1;
        if (expire) begin
            if (s.reload) n.value = s.load;
            else          n.en    = 1'b0;
        end
        if (clr || tick) n.cnt = 8'd0;
        else if (s.en)   n.cnt = s.cnt + 8'd1;
        if (wr) begin
            case (sel)
                0: begin
                    n.en     = pwdata[0];
                    n.reload = pwdata[1];
                    n.ie     = pwdata[2];
                    n.presc  = pwdata[15:8];
                end
                1: begin
                    n.load  = pwdata;
                    n.value = pwdata;
                end
                3: if (pwdata[0]) n.flag = 1'b0;
                default: ;
            endcase
        end
        if (expire) n.flag = 1'b1;
        return n;
    endfunction

    function automatic logic [31:0] model_read(input model_t s, input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a[3:2])
            2'd0:    r = {16'h0, s.presc, 5'h0, s.ie, s.reload, s.en};
            2'd1:    r = s.load;
            2'd2:    r = s.value;
            default: r = {31'h0, s.flag};
        endcase
        return r;
    endfunction

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) m <= '0;
        else        m <= model_next(m, PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] rdata, output logic irq,
                            output logic [31:0] exp_rdata, output logic exp_irq);
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1;
        rdata     = PRDATA;
        irq       = IRQ;
        exp_rdata = model_read(m, a);
        exp_irq   = m.flag & m.ie;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic hold_read(input logic [31:0] a);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESET = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    task automatic apply_stimulus();
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_write) begin
                apb_write(vecs[i].addr, vecs[i].data);
                #1;
                check_output($sformatf("vec%0d_irq", i), {31'h0, IRQ}, {31'h0, vecs[i].exp_irq});
            end else begin
                apb_read(vecs[i].addr, rd, ri, mrd, mri);
                check_output($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
                check_output($sformatf("vec%0d_irq", i), {31'h0, ri}, {31'h0, vecs[i].exp_irq});
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0;

        vecs[0]  = '{1'b1, 32'h0000_0004, 32'h0000_1234, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h0000_1234, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_1234, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_1234, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_FF06, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_000C, 32'h0,         32'h0,         1'b0};
        vecs[8]  = '{1'b0, 32'hFFFF_FFF7, 32'h0,         32'h0000_1234, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};
        vecs[11] = '{1'b0, 32'h1000_0008, 32'h0,         32'h0000_1234, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_000C, 32'h0000_0001, 32'h0,         1'b0};
        vecs[13] = '{1'b0, 32'h0000_000C, 32'h0,         32'h0,         1'b0};

        // Reset held, then reset asserted asynchronously with the interrupt live.
        repeat (3) @(negedge HCLK);
        #1;
        check_output("rst_irq", {31'h0, IRQ}, 32'h0);
        check_output("rst_prdata_idle", PRDATA, 32'h0);
        hold_read(32'h8);
        #1;
        check_output("rst_prdata_value", PRDATA, 32'h0);
        PSEL = 1'b0;
        HRESET = 1'b0;
        apb_write(32'h4, 32'd2);
        apb_write(32'h0, 32'h0000_0007);
        repeat (7) @(negedge HCLK);
        #1;
        check_output("pre_rst_irq", {31'h0, IRQ}, 32'h1);
        #2;
        HRESET = 1'b1;
        #1;
        check_output("async_rst_irq", {31'h0, IRQ}, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apb_read(32'(i * 4), rd, ri, mrd, mri);
            check_output($sformatf("post_rst_reg%0d", i), rd, 32'h0);
            check_output($sformatf("post_rst_irq%0d", i), {31'h0, ri}, 32'h0);
        end
        repeat (10) @(negedge HCLK);
        apb_read(32'h8, rd, ri, mrd, mri);
        check_output("idle_value", rd, 32'h0);
        apb_read(32'h0, rd, ri, mrd, mri);
        check_output("idle_ctrl", rd, 32'h0);

        apply_stimulus();

        // One-shot countdown from 5 with no prescaling.
        do_reset();
        apb_write(32'h4, 32'd5);
        apb_write(32'h0, 32'h0000_0005);
        hold_read(32'h8);
        #1;
        check_output("oneshot_v0", PRDATA, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge HCLK);
            #1;
            check_output($sformatf("oneshot_v%0d", k), PRDATA, 32'(5 - k));
            check_output($sformatf("oneshot_irq%0d", k), {31'h0, IRQ}, 32'h0);
        end
        @(negedge HCLK);
        PADDR = 32'hC;
        #1;
        check_output("oneshot_flag", PRDATA, 32'h1);
        @(negedge HCLK);
        #1;
        check_output("oneshot_irq", {31'h0, IRQ}, 32'h1);
        PADDR = 32'h0;
        #1;
        check_output("oneshot_ctrl", PRDATA, 32'h0000_0004);
        PADDR = 32'h8;
        #1;
        check_output("oneshot_hold0", PRDATA, 32'h0);
        PSEL = 1'b0;

        // Periodic reload, period (3+1)*(3+1) = 16 cycles.
        do_reset();
        apb_write(32'h4, 32'd3);
        apb_write(32'h0, 32'h0000_0303);
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) @(negedge HCLK);
            hold_read(32'h8);
            #1;
            check_output($sformatf("periodic_v%0d", k), PRDATA, 32'(3 - ((k / 4) % 4)));
            PADDR = 32'hC;
            #1;
            check_output($sformatf("periodic_flag%0d", k), PRDATA, (k >= 16) ? 32'h1 : 32'h0);
        end
        PSEL = 1'b0;

        // Flag clear landing on the expiry edge loses to the set.
        do_reset();
        apb_write(32'h4, 32'd3);
        apb_write(32'h0, 32'h0000_0307);
        repeat (13) @(negedge HCLK);
        apb_write(32'hC, 32'h1);
        apb_read(32'hC, rd, ri, mrd, mri);
        check_output("w1c_collide_flag", rd, 32'h1);
        check_output("w1c_collide_irq", {31'h0, ri}, 32'h1);
        apb_write(32'hC, 32'h1);
        apb_read(32'hC, rd, ri, mrd, mri);
        check_output("w1c_clear_flag", rd, 32'h0);
        check_output("w1c_clear_irq", {31'h0, ri}, 32'h0);

        // LOAD writes override a tick and restart the prescaler.
        do_reset();
        apb_write(32'h4, 32'd100);
        apb_write(32'h0, 32'h0000_0301);
        repeat (5) @(negedge HCLK);
        apb_write(32'h4, 32'h10);
        hold_read(32'h8);
        #1;
        check_output("loadprio_v8", PRDATA, 32'h10);
        repeat (3) @(negedge HCLK);
        #1;
        check_output("loadprio_v11", PRDATA, 32'h10);
        @(negedge HCLK);
        #1;
        check_output("loadprio_v12", PRDATA, 32'h0F);
        apb_write(32'h4, 32'h20);
        hold_read(32'h8);
        #1;
        check_output("presc_clr_v15", PRDATA, 32'h20);
        repeat (3) @(negedge HCLK);
        #1;
        check_output("presc_clr_v18", PRDATA, 32'h20);
        @(negedge HCLK);
        #1;
        check_output("presc_clr_v19", PRDATA, 32'h1F);
        PSEL = 1'b0;

        // Protocol corners: setup-only write, enable without select, unselected read.
        do_reset();
        apb_write(32'h4, 32'h55);
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'hABCD;
        #1;
        check_output("proto_write_prdata", PRDATA, 32'h0);
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b1;
        @(negedge HCLK);
        PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h8;
        #1;
        check_output("proto_unsel_read", PRDATA, 32'h0);
        apb_read(32'h4, rd, ri, mrd, mri);
        check_output("proto_load", rd, 32'h55);
        apb_read(32'h8, rd, ri, mrd, mri);
        check_output("proto_value", rd, 32'h55);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int op, idx;
            op  = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, 3));
            addr = $urandom;
            addr[3:2] = 2'(idx);
            if (op < 2) begin
                repeat ($urandom_range(1, 4)) @(negedge HCLK);
            end else if (op < 6) begin
                case (idx)
                    0: begin
                        data = $urandom;
                        data[0] = ($urandom_range(0, 3) != 0);
                        data[15:8] = 8'($urandom_range(0, 3));
                    end
                    1:       data = 32'($urandom_range(0, 10));
                    default: data = $urandom;
                endcase
                apb_write(addr, data);
            end else begin
                apb_read(addr, rd, ri, mrd, mri);
                check_output($sformatf("rand%0d_rdata", n), rd, mrd);
                check_output($sformatf("rand%0d_irq", n), {31'h0, ri}, {31'h0, mri});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_timer_slave.md
APB_TIMER_SLAVE -- requirements
Module: apb_timer_slave

Interface
REQ-001: Parameter PRESC_W, default 8, SHALL set the prescaler width.
REQ-002: HCLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: HRESET  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004: PSEL  input  1  slave select from bridge.
REQ-005: PENABLE  input  1  access-phase indicator.
REQ-006: PWRITE  input  1  1 = write, 0 = read.
REQ-007: PADDR  input  32  byte address; only PADDR[3:2] decoded, all other bits ignored.
REQ-008: PWDATA  input  32  write data.
REQ-009: PRDATA  output  32  read data to bridge.
REQ-010: IRQ  output  1  level interrupt, equal to STATUS.FLAG & CTRL.IE.

Function
REQ-011: Zero-wait-state APB slave; no PREADY and no PSLVERR.
REQ-012: Write strobe = PSEL & PENABLE & PWRITE; the register updates on that edge only, never in setup phase.
REQ-013: Register map:
- 0x0 CTRL: [0] EN, [1] RELOAD, [2] IE, [8+PRESC_W-1:8] PRESCALE; other bits read 0.
- 0x4 LOAD: 32-bit reload value.
- 0x8 VALUE: read-only current count.
- 0xC STATUS: [0] FLAG, write-1-to-clear.
REQ-014: PRDATA = combinational mux on PADDR[3:2] when PSEL & !PWRITE; 32'h0 otherwise.
REQ-015: Writes to VALUE are ignored.
REQ-016: Prescaler counter, PRESC_W bits, increments each cycle while EN=1. When it equals PRESCALE it returns to 0 and issues a one-cycle tick.
REQ-017: On tick with VALUE != 0, VALUE decrements by 1.
REQ-018: On tick with VALUE == 0 (expiry):
- FLAG sets.
- If RELOAD=1, VALUE <= LOAD.
- Else EN clears and VALUE holds at 0 (one-shot).
REQ-019: Expiry period SHALL be (LOAD+1)*(PRESCALE+1) cycles.
REQ-020: A LOAD write SHALL copy PWDATA into both LOAD and VALUE and clear the prescaler. This takes priority over a same-cycle tick.
REQ-021: Writing EN=0 SHALL clear the prescaler and freeze VALUE. Writing EN=1 resumes from the frozen VALUE.
REQ-022: If a FLAG W1C and a hardware expiry occur in the same cycle, the set SHALL win.
REQ-023: A CTRL write in the same cycle as a one-shot expiry SHALL take the written EN value.
REQ-024: IRQ SHALL derive from registered state only (no PWDATA path) and assert the cycle after FLAG sets.

Reset
REQ-025: While HRESET=1:
- CTRL, LOAD, VALUE, FLAG and the prescaler are all 0.
- IRQ=0; PRDATA=0 when PSEL=0.
REQ-026: Reset mid-count or mid-transfer SHALL abort immediately. After deassertion the timer stays idle until software sets EN.

Structure
REQ-027: A shared package apb_timer_pkg SHALL hold the register offset constants, CTRL bit positions and the STATUS FLAG bit position.
REQ-028: The prescaler SHALL be the single sub-module timer_prescaler, with inputs en, clr and presc, and output tick.
REQ-029: Estimated size: 150–250 lines of RTL.

Verification
REQ-030: Reset scenario: assert HRESET mid-count -> all reads return 0 and IRQ=0 after release.
REQ-031: LOAD/VALUE scenario: write LOAD=5, then CTRL=0x0000_0005 (EN, IE, PRESCALE=0) -> VALUE reads 5,4,...,0. FLAG=1 at cycle 6 after the CTRL write, IRQ=1 the next cycle, EN reads 0.
REQ-032: Periodic scenario: LOAD=3, CTRL=0x0000_0303 (EN, RELOAD, PRESCALE=3) -> FLAG sets every 16 cycles and VALUE reloads to 3.
REQ-033: W1C-collision scenario: write STATUS=1 in the exact expiry cycle -> FLAG remains 1. A later STATUS=1 write clears FLAG and drops IRQ.
REQ-034: LOAD-priority scenario: write LOAD=0x10 in a tick cycle -> VALUE reads 0x10, not 0x0F, and the prescaler restarts from 0.
REQ-035: Protocol scenario: a setup-only phase (PENABLE=0, PWRITE=1) to LOAD -> no change. A read of offset 0x8 with PSEL=0 -> PRDATA=0. A write to VALUE -> ignored.
